// File: rtl/branch_pkg.sv
// Shared encodings for the next-PC unit: PC source select, branch condition codes
// and the sequential PC increment.
package branch_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_POP    = 2'b10,
    PC_CALL   = 2'b11
  } pcsrc_e;

  typedef enum logic [2:0] {
    COND_ZERO   = 3'b000,
    COND_NZERO  = 3'b001,
    COND_NEG    = 3'b010,
    COND_NNEG   = 3'b011,
    COND_POS    = 3'b100,
    COND_NPOS   = 3'b101,
    COND_ALWAYS = 3'b110,
    COND_NEVER  = 3'b111
  } cond_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/branch_ras.sv
// Circular return-address stack; push/pop take effect on the next clock edge.
// A push while full overwrites the oldest entry; a pop while empty only raises underflow.
module branch_ras #(
  parameter int unsigned PC_BITS   = 32,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [PC_BITS-1:0]           push_data,
  output logic [PC_BITS-1:0]           top_data,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_BITS-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]   top_q, top_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  assign full      = (cnt_q == CNT_W'(RAS_DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // top_q is the next free slot; when full that slot holds the oldest entry.
  assign top_data = mem_q[top_q - PTR_W'(1)];

  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (push) begin
      top_d = top_q + PTR_W'(1);
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        top_d = top_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[top_q] <= push_data;
    end
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Registered next-PC unit: PC register, signed-condition branches and call/return via a RAS.
// All PC/RAS updates land one cycle later; stall holds every register and drops the pending op.
module branch_pc_unit #(
  parameter int unsigned               REG_BITS  = 32,
  parameter int unsigned               PC_BITS   = 32,
  parameter int unsigned               RAS_DEPTH = 8,
  parameter logic [PC_BITS-1:0]        RESET_PC  = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [1:0]                   PCSrc,
  input  logic [2:0]                   opcode2,
  input  logic [REG_BITS-1:0]          operand,
  input  logic [PC_BITS-1:0]           branch_target,
  output logic [PC_BITS-1:0]           pc,
  output logic                         branch,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  import branch_pkg::*;

  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [PC_BITS-1:0] seq;
  logic [PC_BITS-1:0] ras_top;
  logic               ras_push, ras_pop;

  function automatic logic cond_hit(input logic [2:0] code, input logic [REG_BITS-1:0] v);
    logic is_zero;
    logic is_neg;
    logic hit;
    is_zero = (v == '0);
    is_neg  = v[REG_BITS-1];
    hit     = 1'b0;
    case (cond_e'(code))
      COND_ZERO:   hit = is_zero;
      COND_NZERO:  hit = !is_zero;
      COND_NEG:    hit = is_neg;
      COND_NNEG:   hit = !is_neg;
      COND_POS:    hit = !is_neg && !is_zero;
      COND_NPOS:   hit = is_neg || is_zero;
      COND_ALWAYS: hit = 1'b1;
      COND_NEVER:  hit = 1'b0;
      default:     hit = 1'b0;
    endcase
    return hit;
  endfunction

  assign seq = pc_q + PC_BITS'(PC_INC);
  assign pc  = pc_q;

  always_comb begin
    branch   = 1'b0;
    pc_d     = seq;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    case (pcsrc_e'(PCSrc))
      PC_SEQ: begin
        pc_d = seq;
      end
      PC_BRANCH: begin
        branch = cond_hit(opcode2, operand);
        if (branch) pc_d = branch_target;
      end
      PC_POP: begin
        branch  = !ras_empty;
        ras_pop = 1'b1;
        if (!ras_empty) pc_d = ras_top;
      end
      PC_CALL: begin
        branch   = 1'b1;
        ras_push = 1'b1;
        pc_d     = branch_target;
      end
      default: begin
        pc_d = seq;
      end
    endcase
    // Stall discards the pending op but leaves the branch indication visible.
    if (stall) begin
      pc_d     = pc_q;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  branch_ras #(
    .PC_BITS   (PC_BITS),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq),
    .top_data  (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit (RESET_PC=0x100, RAS_DEPTH=4): queue-based reference model
// checked every negedge, plus directed vectors with literal expectations.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  PCSrc;
  logic [2:0]  opcode2;
  logic [31:0] operand;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        branch;
  logic [2:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_overflow;
  logic        ras_underflow;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  branch_pc_unit #(
    .REG_BITS  (32),
    .PC_BITS   (32),
    .RAS_DEPTH (4),
    .RESET_PC  (32'h100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .PCSrc         (PCSrc),
    .opcode2       (opcode2),
    .operand       (operand),
    .branch_target (branch_target),
    .pc            (pc),
    .branch        (branch),
    .ras_count     (ras_count),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: return addresses kept in a queue, newest at the back.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_of;
  bit          m_uf;

  function automatic logic m_cond(input logic [2:0] code, input logic [31:0] v);
    int signed s;
    s = $signed(v);
    case (code)
      3'd0: return s == 0;
      3'd1: return s != 0;
      3'd2: return s < 0;
      3'd3: return s >= 0;
      3'd4: return s > 0;
      3'd5: return s <= 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_branch();
    case (PCSrc)
      2'd0: return 1'b0;
      2'd1: return m_cond(opcode2, operand);
      2'd2: return m_ras.size() != 0;
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_pc = 32'h100;
        m_ras.delete();
        m_of = 1'b0;
        m_uf = 1'b0;
      end else if (!stall) begin
        case (PCSrc)
          2'd0: m_pc = m_pc + 32'd4;
          2'd1: m_pc = m_cond(opcode2, operand) ? branch_target : m_pc + 32'd4;
          2'd2: begin
            if (m_ras.size() > 0) begin
              m_pc = m_ras.pop_back();
            end else begin
              m_pc = m_pc + 32'd4;
              m_uf = 1'b1;
            end
          end
          default: begin
            if (m_ras.size() == 4) begin
              void'(m_ras.pop_front());
              m_of = 1'b1;
            end
            m_ras.push_back(m_pc + 32'd4);
            m_pc = branch_target;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model pc", pc, m_pc);
      chk("model branch", branch, m_branch());
      chk("model ras_count", ras_count, 64'(m_ras.size()));
      chk("model ras_empty", ras_empty, m_ras.size() == 0);
      chk("model ras_full", ras_full, m_ras.size() == 4);
      chk("model overflow", ras_overflow, m_of);
      chk("model underflow", ras_underflow, m_uf);
    end
  end

  task automatic cyc(input logic [1:0] s, input logic [2:0] op, input logic [31:0] v,
                     input logic [31:0] t, input logic st, output logic br);
    PCSrc         = s;
    opcode2       = op;
    operand       = v;
    branch_target = t;
    stall         = st;
    @(negedge clk);
    br = branch;
    @(posedge clk);
    #1;
  endtask

  // Taken bits per condition code, bit k = operand {0, 5, -5}[k].
  logic [2:0]  tbl [8] = '{3'b001, 3'b110, 3'b100, 3'b011, 3'b010, 3'b101, 3'b111, 3'b000};
  logic [31:0] ops [3] = '{32'd0, 32'd5, 32'hFFFF_FFFB};
  logic [31:0] ret_exp [4] = '{32'h4004, 32'h3004, 32'h2004, 32'h1004};

  initial begin
    logic        br;
    logic [31:0] prev;
    reset = 1'b1; stall = 1'b0; PCSrc = 2'd0; opcode2 = 3'd0;
    operand = 32'd0; branch_target = 32'd0;
    #16;
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("reset pc", pc, 32'h100);
    chk("reset count", ras_count, 0);
    chk("reset empty", ras_empty, 1);

    cyc(2'd0, 3'd0, 32'd0, 32'd0, 1'b0, br);
    chk("seq branch", br, 0);
    chk("seq pc1", pc, 32'h104);
    cyc(2'd0, 3'd0, 32'd0, 32'd0, 1'b0, br);
    chk("seq pc2", pc, 32'h108);
    cyc(2'd0, 3'd0, 32'd0, 32'd0, 1'b0, br);
    chk("seq pc3", pc, 32'h10C);

    for (int op = 0; op < 8; op++) begin
      for (int k = 0; k < 3; k++) begin
        prev = m_pc;
        cyc(2'd1, 3'(op), ops[k], 32'h40, 1'b0, br);
        chk($sformatf("cond br op%0d v%0d", op, k), br, tbl[op][k]);
        chk($sformatf("cond pc op%0d v%0d", op, k), pc, tbl[op][k] ? 32'h40 : prev + 32'd4);
      end
    end

    cyc(2'd1, 3'd6, 32'd0, 32'h200, 1'b0, br);
    chk("jump 200", pc, 32'h200);
    cyc(2'd3, 3'd0, 32'd0, 32'h300, 1'b0, br);
    chk("call1 br", br, 1);
    chk("call1 pc", pc, 32'h300);
    chk("call1 cnt", ras_count, 1);
    cyc(2'd0, 3'd0, 32'd0, 32'd0, 1'b0, br);
    chk("after call1 pc", pc, 32'h304);
    cyc(2'd3, 3'd0, 32'd0, 32'h400, 1'b0, br);
    chk("call2 pc", pc, 32'h400);
    chk("call2 cnt", ras_count, 2);
    cyc(2'd2, 3'd0, 32'd0, 32'd0, 1'b0, br);
    chk("ret1 br", br, 1);
    chk("ret1 pc", pc, 32'h308);
    chk("ret1 cnt", ras_count, 1);
    cyc(2'd2, 3'd0, 32'd0, 32'd0, 1'b0, br);
    chk("ret2 pc", pc, 32'h204);
    chk("ret2 cnt", ras_count, 0);

    for (int i = 1; i <= 5; i++) begin
      cyc(2'd3, 3'd0, 32'd0, 32'(i * 32'h1000), 1'b0, br);
      chk($sformatf("nest call%0d ovf", i), ras_overflow, i == 5);
    end
    chk("nest full", ras_full, 1);
    chk("nest cnt", ras_count, 4);
    chk("nest pc", pc, 32'h5000);
    for (int i = 0; i < 4; i++) begin
      cyc(2'd2, 3'd0, 32'd0, 32'd0, 1'b0, br);
      chk($sformatf("unwind br%0d", i), br, 1);
      chk($sformatf("unwind pc%0d", i), pc, ret_exp[i]);
    end
    chk("unwind empty", ras_empty, 1);
    chk("unwind no underflow yet", ras_underflow, 0);
    cyc(2'd2, 3'd0, 32'd0, 32'd0, 1'b0, br);
    chk("underflow br", br, 0);
    chk("underflow pc", pc, 32'h1008);
    chk("underflow flag", ras_underflow, 1);
    chk("underflow cnt", ras_count, 0);

    cyc(2'd3, 3'd0, 32'd0, 32'h600, 1'b1, br);
    chk("stall1 br", br, 1);
    chk("stall1 pc", pc, 32'h1008);
    chk("stall1 cnt", ras_count, 0);
    cyc(2'd3, 3'd0, 32'd0, 32'h600, 1'b1, br);
    chk("stall2 pc", pc, 32'h1008);
    chk("stall2 cnt", ras_count, 0);
    cyc(2'd3, 3'd0, 32'd0, 32'h600, 1'b0, br);
    chk("unstall pc", pc, 32'h600);
    chk("unstall cnt", ras_count, 1);
    cyc(2'd2, 3'd0, 32'd0, 32'd0, 1'b0, br);
    chk("stall ret pc", pc, 32'h100C);
    chk("stall ret empty", ras_empty, 1);

    cyc(2'd3, 3'd0, 32'd0, 32'h700, 1'b0, br);
    cyc(2'd3, 3'd0, 32'd0, 32'h800, 1'b0, br);
    cyc(2'd3, 3'd0, 32'd0, 32'h900, 1'b0, br);
    chk("pre-reset cnt", ras_count, 3);
    chk("pre-reset ovf", ras_overflow, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async pc", pc, 32'h100);
    chk("async cnt", ras_count, 0);
    chk("async empty", ras_empty, 1);
    chk("async ovf", ras_overflow, 0);
    chk("async unf", ras_underflow, 0);
    PCSrc = 2'd0;
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset pc", pc, 32'h104);

    cyc(2'd1, 3'd6, 32'd0, 32'hFFFF_FFFC, 1'b0, br);
    chk("wrap setup pc", pc, 32'hFFFF_FFFC);
    cyc(2'd0, 3'd0, 32'd0, 32'd0, 1'b0, br);
    chk("wrap pc", pc, 32'h0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
Registered next-PC unit that replaces the combinational branch decision with a full PC update path. It holds the PC register, evaluates an extended set of branch conditions on a register operand, and supports call/return through a parametrised return-address stack (RAS). It sits between decode (PCSrc, opcode2, target) and instruction fetch (pc) in the single-cycle core.

Parameters:
REG_BITS, 32, width of the condition operand
PC_BITS, 32, width of the PC and return addresses
RAS_DEPTH, 8, number of RAS entries; must be a power of 2 and at least 2
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
stall  input  1  when 1, holds PC and RAS for this cycle
PCSrc  input  2  00 sequential, 01 conditional branch, 10 return (pop), 11 call (push)
opcode2  input  3  branch condition code, used only when PCSrc=01
operand  input  REG_BITS  value tested by the condition (two's complement)
branch_target  input  PC_BITS  target for a taken branch or a call
pc  output  PC_BITS  current PC (registered)
branch  output  1  combinational: this cycle redirects the PC
ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries (registered)
ras_empty  output  1  ras_count==0
ras_full  output  1  ras_count==RAS_DEPTH
ras_overflow  output  1  sticky: a push was made while full
ras_underflow  output  1  sticky: a pop was made while empty

Behaviour:
- Reset (asynchronous, takes effect immediately and may occur mid-operation): pc=RESET_PC, ras_count=0, top pointer=0, both sticky flags=0. RAS entry contents are don't-care. branch follows its inputs.
- seq = pc+4, computed modulo 2^PC_BITS (wraps from all-ones-minus-3 to 0).
- Condition codes (operand treated as signed):
  000 zero: ==0
  001 nzero: !=0
  010 neg: <0
  011 nneg: >=0
  100 pos: >0
  101 npos: <=0
  110 always
  111 never
- branch is combinational:
  - PCSrc=00: 0
  - PCSrc=01: condition result
  - PCSrc=10: !ras_empty
  - PCSrc=11: 1
  - stall does not mask branch.
- Next-PC update on each rising edge with stall=0; all updates take one cycle:
  - 00: pc<=seq.
  - 01: pc<=branch_target if the condition holds, else seq.
  - 10, not empty: pc<=top entry; pop; ras_count decrements.
  - 10, empty: pc<=seq; ras_underflow<=1; count stays at 0.
  - 11, not full: push seq; pc<=branch_target; ras_count increments.
  - 11, full: the push overwrites the oldest entry (circular buffer); ras_count stays at RAS_DEPTH; ras_overflow<=1; pc<=branch_target.
- Top pointer wraps modulo RAS_DEPTH in both directions.
- stall=1: pc, RAS contents, pointer, count and flags all hold. A pending push or pop is discarded, not deferred.
- Sticky flags clear only on reset.
- Push and pop never occur in the same cycle; PCSrc encoding guarantees this.

Decomposition:
- Shared package (branch_pkg):
  - PCSrc encodings: PC_SEQ, PC_BRANCH, PC_POP, PC_CALL.
  - Condition codes: COND_ZERO … COND_NEVER.
  - PC increment constant: PC_INC=4.
- One sub-module: branch_ras (circular RAS).
  - Ports: clk, reset, push, pop, push_data, top_data, count, full, empty, overflow, underflow.
  - Parametrised by PC_BITS and RAS_DEPTH.
- Condition evaluation stays inline as a combinational function in branch_pc_unit.

Test Plan:
- Reset with RESET_PC=0x100, then three cycles of PCSrc=00 -> pc=0x100, 0x104, 0x108, 0x10C; branch=0.
- PCSrc=01, then each opcode2 000..111 against operand values 0, 5 and 0xFFFFFFFB, target=0x40 -> branch and the next pc match the condition table. Cases include 010/-5 taken, 100/0 not taken, 101/0 taken, 111 never taken.
- At pc=0x200, call to 0x300; at pc=0x304, call to 0x400; then two returns -> pc sequence 0x300, 0x304, 0x400, 0x308, 0x204. ras_count goes 1, 2, 1, 0.
- RAS_DEPTH=4: five nested calls, then five returns -> ras_overflow=1 after the 5th call. The first four returns give the newest four return addresses; the 5th return finds the RAS empty, so pc=seq and ras_underflow=1.
- Call with stall=1 for 2 cycles, then stall=0 -> pc and ras_count hold during the stall; exactly one push occurs after it.
- Reset asserted asynchronously mid-cycle with ras_count=3 and sticky flags set -> outputs return to reset values immediately, with no clock edge.
